// File: rtl/delay_pkg.sv
// delay_pkg: shared sample format, default sizes and FSM encoding for the delay-line memory stage.
package delay_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int MEMORY_SIZE  = 8192;
  localparam int DELAY_FORMAT = DATA_WIDTH - 1;
  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_RD_DONE, ST_CLEAR} state_t;
endpackage

// File: rtl/delay_mem_ram.sv
// delay_mem_ram: single-port read-first synchronous sample RAM.
module delay_mem_ram #(
  parameter  int data_width  = 16,
  parameter  int memory_size = 8192,
  localparam int addr_width  = $clog2(memory_size)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout
);
  logic [data_width-1:0] r_mem [memory_size];
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
    dout <= r_mem[addr];
  end
endmodule

// File: rtl/delay_mem_ctrl.sv
// delay_mem_ctrl: services level-held read/write requests against the sample RAM with one-shot completion pulses.
// Optional power-up zero sweep of the RAM is enabled by defining DELAY_MEM_CLEAR_EN.
module delay_mem_ctrl import delay_pkg::*; #(
  parameter  int data_width  = DATA_WIDTH,
  parameter  int memory_size = MEMORY_SIZE,
  localparam int addr_width  = $clog2(memory_size)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_read_req,
  input  logic                         mem_write_req,
  input  logic        [addr_width-1:0] mem_read_addr,
  input  logic        [addr_width-1:0] mem_write_addr,
  input  logic signed [data_width-1:0] mem_wr_data,
  output logic signed [data_width-1:0] mem_rd_data,
  output logic                         mem_read_valid,
  output logic                         mem_write_ack,
  output logic                         addr_oob,
  output logic                         busy
);
  localparam logic [addr_width:0] mem_limit = (addr_width+1)'(memory_size);
`ifdef DELAY_MEM_CLEAR_EN
  localparam state_t rst_state = ST_CLEAR;
`else
  localparam state_t rst_state = ST_IDLE;
`endif
  state_t r_state, w_next;
  logic r_rd_armed, r_wr_armed, r_rd_oob, r_valid, r_ack, r_oob;
  logic [data_width-1:0] r_rd_data, w_din, w_dout;
  logic [addr_width-1:0] w_addr;
  logic w_accept, w_wr_go, w_rd_go, w_wr_oob, w_rd_oob, w_we, w_clr, w_clr_last;
`ifdef DELAY_MEM_CLEAR_EN
  logic [addr_width-1:0] r_clr_addr;
  logic r_busy;
  always_ff @(posedge clk) begin
    r_clr_addr <= reset ? '0 : w_clr ? r_clr_addr + 1'b1 : '0;
    r_busy <= reset ? 1'b1 : w_next == ST_CLEAR;
  end
  assign w_clr = r_state == ST_CLEAR;
  assign w_clr_last = r_clr_addr == addr_width'(memory_size - 1);
  assign busy = r_busy;
`else
  logic [addr_width-1:0] r_clr_addr;
  assign r_clr_addr = '0;
  assign w_clr = 1'b0;
  assign w_clr_last = 1'b0;
  assign busy = 1'b0;
`endif
  always_comb begin
    w_accept = r_state == ST_IDLE || r_state == ST_RD_DONE;
    w_wr_go  = w_accept && mem_write_req && r_wr_armed;
    w_rd_go  = w_accept && mem_read_req && r_rd_armed && !w_wr_go;
    w_wr_oob = {1'b0, mem_write_addr} >= mem_limit;
    w_rd_oob = {1'b0, mem_read_addr} >= mem_limit;
    w_we     = w_clr || (w_wr_go && !w_wr_oob);
    w_addr   = w_clr ? r_clr_addr : w_wr_go ? mem_write_addr : mem_read_addr;
    w_din    = w_clr ? '0 : mem_wr_data;
    w_next   = w_clr ? (w_clr_last ? ST_IDLE : ST_CLEAR) :
               w_rd_go ? ST_RD_WAIT :
               r_state == ST_RD_WAIT ? ST_RD_DONE : ST_IDLE;
  end
  // Armed flags stop a still-held request from being serviced a second time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= rst_state;
      r_rd_armed <= 1'b1;
      r_wr_armed <= 1'b1;
      r_rd_oob   <= 1'b0;
      r_rd_data  <= '0;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_armed <= !mem_read_req || (r_rd_armed && !w_rd_go);
      r_wr_armed <= !mem_write_req || (r_wr_armed && !w_wr_go);
      r_rd_oob   <= w_rd_go ? w_rd_oob : r_rd_oob;
      r_rd_data  <= r_state == ST_RD_WAIT ? (r_rd_oob ? '0 : w_dout) : r_rd_data;
      r_valid    <= r_state == ST_RD_WAIT;
      r_ack      <= w_wr_go;
      r_oob      <= (w_wr_go && w_wr_oob) || (r_state == ST_RD_WAIT && r_rd_oob);
    end
  end
  assign mem_rd_data    = r_rd_data;
  assign mem_read_valid = r_valid;
  assign mem_write_ack  = r_ack;
  assign addr_oob       = r_oob;
  delay_mem_ram #(.data_width(data_width), .memory_size(memory_size)) u_ram (
    .clk(clk), .we(w_we), .addr(w_addr), .din(w_din), .dout(w_dout)
  );
endmodule
